seq_shifter: RTL and testbench
==============================

# seq_shifter

Multi-cycle, one-bit-per-cycle shift unit for area-constrained RV32 core configurations. It replaces the combinational barrel shifter in the execute stage. It uses the same 2-bit shift-type encoding as the barrel shifter. Requests and responses use a valid/ready handshake, so the pipeline stalls while a shift is in progress.

## Interface
Parameters:
- XLEN, 32, operand/result width; shift amount width is $clog2(XLEN) (5 at default)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_type  in  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through
- req_data  in  XLEN  operand
- req_shamt  in  $clog2(XLEN)  shift amount, unsigned
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  XLEN  result
- busy  out  1  high in any state other than IDLE

## Operation
States:
- IDLE
  - req_ready=1, resp_valid=0, busy=0.
  - A request is accepted on a rising edge with req_valid && req_ready.
  - On accept: latch req_data into the working register, latch req_type, and load count=req_shamt.
  - Next state is DONE if req_shamt==0 or req_type==11; otherwise SHIFT.
- SHIFT
  - req_ready=0, resp_valid=0, busy=1.
  - Each edge shifts the working register by one bit:
    - SLL: left, zero fill.
    - SRL: right, zero fill.
    - SRA: right, fill with the current MSB.
  - Each edge also decrements count. When count==1 before the edge, next state is DONE.
- DONE
  - resp_valid=1, busy=1, req_ready=0.
  - resp_data is driven from the working register and holds stable while resp_valid && !resp_ready.
  - On an edge with resp_ready=1, return to IDLE.

Rules:
- Input capture:
  - req_data, req_type and req_shamt are sampled only on the accept edge.
  - Later changes to these inputs have no effect on the operation in flight.
- req_valid outside IDLE is ignored. It is not queued; the requester holds it until req_ready.
- No acceptance in DONE, even when resp_ready=1 in the same cycle. A new request is accepted at the earliest in the cycle after the response handshake.
- Semantics:
  - The result is bit-exact to the combinational shifter for type_ 00/01/10 over all shamt 0..XLEN-1.
  - Type 11 returns req_data unchanged, regardless of shamt.
- resp_data is the working register in all states. It is defined only while resp_valid=1.

## Timing
- Reset:
  - Asserting rst_n low forces state IDLE immediately, regardless of clk.
  - Reset values: req_ready=1, resp_valid=0, busy=0, resp_data=0, count=0.
- Reset mid-operation:
  - Any in-flight shift or pending response is discarded.
  - No resp_valid is produced for the aborted request.
- Latency:
  - The accept cycle is cycle 0. resp_valid is first high in cycle shamt+1.
  - shamt==0 and type 11 both give resp_valid in cycle 1.
  - Maximum latency is XLEN cycles (shamt=31).
- Throughput: one request per shamt+2 cycles when resp_ready is held high.
- Back-pressure: resp_valid stays high and resp_data stays constant for every cycle resp_ready is low.

## Test plan
- SLL: req_data=0x00000001, shamt=31, type 00 → resp_valid in cycle 32, resp_data=0x80000000; busy high in cycles 1..32.
- SRL: req_data=0x00000002, shamt=1, type 01 → resp_valid in cycle 2, resp_data=0x00000001.
- SRA:
  - req_data=0x80000000, shamt=31, type 10 → resp_data=0xFFFFFFFF.
  - req_data=0x40000000, shamt=4, type 10 → resp_data=0x04000000.
- Zero shift and pass-through:
  - shamt=0, type 10, req_data=0xDEADBEEF → resp_data=0xDEADBEEF in cycle 1.
  - type 11, shamt=7, req_data=0x12345678 → resp_data=0x12345678 in cycle 1.
- Back-pressure and input isolation:
  - Hold resp_ready=0 for 5 cycles after resp_valid → resp_data constant throughout, req_ready=0.
  - Change req_data/req_valid during SHIFT → result unaffected.
  - After the response handshake → req_ready=1 the next cycle.
- Reset and reference model:
  - Drop rst_n during SHIFT of shamt=20 → outputs take reset values immediately with no resp_valid; the next request completes correctly.
  - Random sweep of 1000 ops with random resp_ready stalls → every result matches a reference model of SLL/SRL/SRA.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit that moves the operand by one bit per
// clock. It understands the barrel-shifter type encoding (SLL/SRL/SRA/pass)
// and talks valid/ready on both the request and the response side.
module seq_shifter #(
    parameter int XLEN = 32,
    localparam int SW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_type,
    input  logic [XLEN-1:0] req_data,
    input  logic [SW-1:0]   req_shamt,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] TYPE_SLL  = 2'b00;
    localparam logic [1:0] TYPE_SRL  = 2'b01;
    localparam logic [1:0] TYPE_SRA  = 2'b10;
    localparam logic [1:0] TYPE_PASS = 2'b11;

    state_t          state_r;
    state_t          state_s;
    logic [XLEN-1:0] work_r;
    logic [XLEN-1:0] work_s;
    logic [1:0]      type_r;
    logic [1:0]      type_s;
    logic [SW-1:0]   count_r;
    logic [SW-1:0]   count_s;
    logic            req_ready_r;
    logic            resp_valid_r;
    logic            busy_r;

    // Next-state, working-register and count computation for the shift FSM.
    always_comb begin
        state_s = state_r;
        work_s  = work_r;
        type_s  = type_r;
        count_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    // Operands are captured only here; later input changes are ignored.
                    work_s  = req_data;
                    type_s  = req_type;
                    count_s = req_shamt;
                    if ((req_shamt == SW'(0)) || (req_type == TYPE_PASS)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                case (type_r)
                    TYPE_SLL: work_s = {work_r[XLEN-2:0], 1'b0};
                    TYPE_SRL: work_s = {1'b0, work_r[XLEN-1:1]};
                    TYPE_SRA: work_s = {work_r[XLEN-1], work_r[XLEN-1:1]};
                    default:  work_s = work_r;
                endcase
                count_s = count_r - SW'(1);
                if (count_r == SW'(1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // No new acceptance here even if the response is taken this cycle.
                if (resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and handshake-output registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            work_r       <= {XLEN{1'b0}};
            type_r       <= 2'b00;
            count_r      <= {SW{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            work_r       <= work_s;
            type_r       <= type_s;
            count_r      <= count_s;
            req_ready_r  <= (state_s == ST_IDLE);
            resp_valid_r <= (state_s == ST_DONE);
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign busy       = busy_r;
    assign resp_data  = work_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and randomised self-checking bench for seq_shifter.
module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [31:0] req_data;
    logic [4:0]  req_shamt;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;

    int vectors = 0;
    int errs    = 0;

    seq_shifter #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_type   (req_type),
        .req_data   (req_data),
        .req_shamt  (req_shamt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] t, input logic [31:0] d, input logic [4:0] s);
        logic [31:0] r;
        case (t)
            2'd0:    r = d << s;
            2'd1:    r = d >> s;
            2'd2:    r = $signed(d) >>> s;
            default: r = d;
        endcase
        return r;
    endfunction

    // Full transaction: accept, scramble inputs during the operation, measure
    // latency, hold back-pressure for 'stall' cycles, then handshake.
    task automatic do_op(input logic [1:0] t, input logic [31:0] d, input logic [4:0] s,
                         input logic [31:0] exp_data, input int stall);
        int lat;
        int exp_lat;
        exp_lat = ((s == 5'd0) || (t == 2'b11)) ? 1 : int'(s) + 1;
        req_valid  = 1'b1;
        req_type   = t;
        req_data   = d;
        req_shamt  = s;
        resp_ready = 1'b0;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b1;
        req_data  = $urandom;
        req_type  = 2'($urandom_range(0, 3));
        req_shamt = 5'($urandom_range(0, 31));
        lat = 1;
        while (!resp_valid && lat < 40) begin
            chk("busy_shift", {31'd0, busy}, 32'd1);
            chk("req_ready_shift", {31'd0, req_ready}, 32'd0);
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_data", resp_data, exp_data);
        chk("busy_done", {31'd0, busy}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_data", resp_data, exp_data);
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("post_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_ready", {31'd0, req_ready}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [1:0]  t;
        logic [31:0] d;
        logic [4:0]  s;
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_type   = 2'b00;
        req_data   = 32'd0;
        req_shamt  = 5'd0;
        resp_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        do_op(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1);
        do_op(2'b01, 32'h0000_0002, 5'd1,  32'h0000_0001, 0);
        do_op(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 0);
        do_op(2'b10, 32'h4000_0000, 5'd4,  32'h0400_0000, 0);
        do_op(2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
        do_op(2'b11, 32'h1234_5678, 5'd7,  32'h1234_5678, 0);
        do_op(2'b01, 32'hF000_000F, 5'd3,  32'h1E00_0001, 5);
        do_op(2'b10, 32'h8765_4321, 5'd8,  32'hFF87_6543, 2);

        // Reset during a long shift: outputs return to reset values at once.
        req_valid = 1'b1;
        req_type  = 2'b00;
        req_data  = 32'h0000_0003;
        req_shamt = 5'd20;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_resp_data", resp_data, 32'd0);
        step();
        step();
        chk("arst_hold_valid", {31'd0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("arst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        do_op(2'b00, 32'h0000_0003, 5'd20, 32'h0030_0000, 0);

        // Randomised sweep against the reference model.
        for (int n = 0; n < 1000; n++) begin
            t = 2'($urandom_range(0, 3));
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            do_op(t, d, s, ref_shift(t, d, s), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
